// File: rtl/sliding_window_3x3.sv
// sliding_window_3x3: raster pixel stream to 3x3 neighbourhood, emitting only fully-populated windows
module sliding_window_3x3 #(
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 256,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] in_pixel,
   output logic              out_valid,
   output logic [DATA_W-1:0] sw_pixels1,
   output logic [DATA_W-1:0] sw_pixels2,
   output logic [DATA_W-1:0] sw_pixels3,
   output logic [DATA_W-1:0] sw_pixels4,
   output logic [DATA_W-1:0] sw_pixels5,
   output logic [DATA_W-1:0] sw_pixels6,
   output logic [DATA_W-1:0] sw_pixels7,
   output logic [DATA_W-1:0] sw_pixels8,
   output logic [DATA_W-1:0] sw_pixels9,
   output logic              frame_done
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   logic [CW-1:0]     r_col, w_col, w_col_nx;
   logic [RW-1:0]     r_row, w_row, w_row_nx;
   logic              w_last_col, w_last_row;
   logic [DATA_W-1:0] r_lb0 [IMG_WIDTH];
   logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];
   logic [DATA_W-1:0] r_win [9];
   always_comb begin
      w_col      = in_sof ? '0 : r_col;
      w_row      = in_sof ? '0 : r_row;
      w_last_col = w_col == CW'(IMG_WIDTH - 1);
      w_last_row = w_row == RW'(IMG_HEIGHT - 1);
      w_col_nx   = w_last_col ? '0 : w_col + 1'b1;
      w_row_nx   = !w_last_col ? w_row : w_last_row ? '0 : w_row + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col      <= '0;
         r_row      <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         r_win      <= '{default: '0};
      end else begin
         out_valid  <= in_valid && w_row >= RW'(2) && w_col >= CW'(2);
         frame_done <= in_valid && w_last_col && w_last_row;
         if (in_valid) begin
            r_col <= w_col_nx;
            r_row <= w_row_nx;
            r_win <= '{r_win[1], r_win[2], r_lb0[w_col],
                       r_win[4], r_win[5], r_lb1[w_col],
                       r_win[7], r_win[8], in_pixel};
         end
      end
   end
   // Line buffers are never emitted before being rewritten, so they carry no reset
   always_ff @(posedge clk) begin
      if (in_valid && !rst) begin
         r_lb0[w_col] <= r_lb1[w_col];
         r_lb1[w_col] <= in_pixel;
      end
   end
   assign sw_pixels1 = r_win[0];
   assign sw_pixels2 = r_win[1];
   assign sw_pixels3 = r_win[2];
   assign sw_pixels4 = r_win[3];
   assign sw_pixels5 = r_win[4];
   assign sw_pixels6 = r_win[5];
   assign sw_pixels7 = r_win[6];
   assign sw_pixels8 = r_win[7];
   assign sw_pixels9 = r_win[8];
endmodule

// File: tb/tb_sliding_window_3x3.sv
// tb_sliding_window_3x3: image-array reference model checked every cycle against a 4x4 and a 256x256 instance
module tb_sliding_window_3x3;
   logic       clk = 1'b0;
   logic       rstv [2];
   logic       v    [2];
   logic       sof  [2];
   logic [7:0] px   [2];
   logic       ov   [2];
   logic       fd   [2];
   logic [7:0] sw   [2][9];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   sliding_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8)) u_small (
      .clk(clk), .rst(rstv[0]), .in_valid(v[0]), .in_sof(sof[0]), .in_pixel(px[0]),
      .out_valid(ov[0]),
      .sw_pixels1(sw[0][0]), .sw_pixels2(sw[0][1]), .sw_pixels3(sw[0][2]),
      .sw_pixels4(sw[0][3]), .sw_pixels5(sw[0][4]), .sw_pixels6(sw[0][5]),
      .sw_pixels7(sw[0][6]), .sw_pixels8(sw[0][7]), .sw_pixels9(sw[0][8]),
      .frame_done(fd[0]));
   sliding_window_3x3 #(.IMG_WIDTH(256), .IMG_HEIGHT(256), .DATA_W(8)) u_big (
      .clk(clk), .rst(rstv[1]), .in_valid(v[1]), .in_sof(sof[1]), .in_pixel(px[1]),
      .out_valid(ov[1]),
      .sw_pixels1(sw[1][0]), .sw_pixels2(sw[1][1]), .sw_pixels3(sw[1][2]),
      .sw_pixels4(sw[1][3]), .sw_pixels5(sw[1][4]), .sw_pixels6(sw[1][5]),
      .sw_pixels7(sw[1][6]), .sw_pixels8(sw[1][7]), .sw_pixels9(sw[1][8]),
      .frame_done(fd[1]));
   // Reference model: each accepted pixel is written into an image at its raster position
   int         pr [2], pc [2];
   logic [7:0] img [2][256][256];
   logic       ev [2], ed [2], er [2];
   logic [7:0] ep [2][9];
   int         mr, mc, mn;
   initial begin
      for (int k = 0; k < 2; k++) begin
         pr[k] = 0; pc[k] = 0; ev[k] = 0; ed[k] = 0; er[k] = 0;
         for (int i = 0; i < 9; i++) ep[k][i] = 8'd0;
      end
   end
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         mn = (k == 1) ? 256 : 4;
         er[k] = rstv[k];
         ev[k] = 1'b0;
         ed[k] = 1'b0;
         if (rstv[k]) begin
            pr[k] = 0;
            pc[k] = 0;
            for (int i = 0; i < 9; i++) ep[k][i] = 8'd0;
         end else if (v[k]) begin
            mr = sof[k] ? 0 : pr[k];
            mc = sof[k] ? 0 : pc[k];
            img[k][mr][mc] = px[k];
            if (mr >= 2 && mc >= 2) begin
               ev[k] = 1'b1;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     ep[k][i*3+j] = img[k][mr-2+i][mc-2+j];
            end
            ed[k] = (mr == mn - 1) && (mc == mn - 1);
            mc++;
            if (mc == mn) begin
               mc = 0;
               mr = (mr == mn - 1) ? 0 : mr + 1;
            end
            pr[k] = mr;
            pc[k] = mc;
         end
      end
   end
   function automatic logic [71:0] pk_dut(input int k);
      logic [71:0] x = '0;
      for (int i = 0; i < 9; i++) x = {x[63:0], sw[k][i]};
      return x;
   endfunction
   function automatic logic [71:0] pk_mod(input int k);
      logic [71:0] x = '0;
      for (int i = 0; i < 9; i++) x = {x[63:0], ep[k][i]};
      return x;
   endfunction
   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Per-cycle comparison plus window logs of the small instance
   logic [71:0] dlog [$], mlog [$];
   int   wcnt [2], mcnt [2], dcnt [2], b2b;
   logic prev_ov0, last_fd_ov;
   initial begin
      wcnt = '{0, 0}; mcnt = '{0, 0}; dcnt = '{0, 0}; b2b = 0; prev_ov0 = 0; last_fd_ov = 0;
   end
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("out_valid[%0d]", k), 72'(ov[k]), 72'(ev[k]));
         chk($sformatf("frame_done[%0d]", k), 72'(fd[k]), 72'(ed[k]));
         if (ev[k] || er[k]) chk($sformatf("window[%0d]", k), pk_dut(k), pk_mod(k));
         wcnt[k] += int'(ov[k]);
         mcnt[k] += int'(ev[k]);
         dcnt[k] += int'(fd[k]);
      end
      if (ov[0]) dlog.push_back(pk_dut(0));
      if (ev[0]) mlog.push_back(pk_mod(0));
      if (ov[0] && prev_ov0) b2b++;
      if (fd[0]) last_fd_ov = ov[0];
      prev_ov0 = ov[0];
   end
   logic [71:0] lit [5];
   initial begin
      lit[0] = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
      lit[1] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
      lit[2] = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
      lit[3] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
      lit[4] = {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110};
   end
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input int k, input logic [7:0] p, input logic s, input int gaps);
      v[k] = 1'b1; px[k] = p; sof[k] = s;
      @(posedge clk);
      #1;
      v[k] = 1'b0; sof[k] = 1'b0;
      idle(gaps);
   endtask
   task automatic clear_logs();
      dlog.delete(); mlog.delete();
      dcnt[0] = 0; b2b = 0; last_fd_ov = 0;
   endtask
   task automatic check_frame(input string name, input int nwin, input int ndone);
      chk({name, " dut windows"}, 72'(dlog.size()), 72'(nwin));
      chk({name, " model windows"}, 72'(mlog.size()), 72'(nwin));
      chk({name, " frame_done count"}, 72'(dcnt[0]), 72'(ndone));
      for (int i = 0; i < 4; i++) begin
         if (i < dlog.size()) chk($sformatf("%s dut literal w%0d", name, i + 1), dlog[i], lit[i]);
         if (i < mlog.size()) chk($sformatf("%s model literal w%0d", name, i + 1), mlog[i], lit[i]);
      end
   endtask
   task automatic frame(input int base, input int gaps);
      for (int i = 0; i < 16; i++) send(0, 8'(base + i), i == 0, gaps);
   endtask
   initial begin
      for (int k = 0; k < 2; k++) begin
         rstv[k] = 1'b1; v[k] = 1'b0; sof[k] = 1'b0; px[k] = 8'd0;
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rstv[0] = 1'b0; rstv[1] = 1'b0;
      chk("reset window", pk_dut(0), 72'd0);
      chk("reset out_valid", 72'(ov[0]), 72'd0);
      clear_logs();
      frame(0, 0);
      idle(3);
      check_frame("continuous", 4, 1);
      chk("frame_done with last window", 72'(last_fd_ov), 72'd1);
      clear_logs();
      frame(0, 3);
      idle(3);
      check_frame("stalled", 4, 1);
      chk("stalled back-to-back valid", 72'(b2b), 72'd0);
      clear_logs();
      frame(0, 0);
      frame(100, 0);
      idle(3);
      check_frame("two frames", 8, 2);
      if (dlog.size() > 4) chk("second frame dut w1", dlog[4], lit[4]);
      if (mlog.size() > 4) chk("second frame model w1", mlog[4], lit[4]);
      clear_logs();
      for (int i = 0; i < 6; i++) send(0, 8'(i), i == 0, 0);
      frame(0, 0);
      idle(3);
      check_frame("sof abort", 4, 1);
      for (int i = 0; i < 11; i++) send(0, 8'(i), i == 0, 0);
      rstv[0] = 1'b1; v[0] = 1'b1; px[0] = 8'd11;
      @(posedge clk);
      #1;
      rstv[0] = 1'b0; v[0] = 1'b0;
      chk("mid-frame reset window", pk_dut(0), 72'd0);
      chk("mid-frame reset out_valid", 72'(ov[0]), 72'd0);
      chk("mid-frame reset frame_done", 72'(fd[0]), 72'd0);
      clear_logs();
      for (int i = 0; i < 16; i++) send(0, 8'(i), 1'b0, 0);
      idle(3);
      check_frame("after reset", 4, 1);
      wcnt[1] = 0; mcnt[1] = 0; dcnt[1] = 0;
      for (int i = 0; i < 65536; i++) send(1, 8'($urandom_range(0, 255)), i == 0, 0);
      idle(3);
      chk("big dut windows", 72'(wcnt[1]), 72'd64516);
      chk("big model windows", 72'(mcnt[1]), 72'd64516);
      chk("big frame_done count", 72'(dcnt[1]), 72'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
